// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - request/control bundle between pipeline stages and the hazard unit
interface hazard_if #(
  parameter int NUM_STAGES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  localparam int SEL_W = $clog2(2 * NUM_STAGES + 1);

  logic [NUM_STAGES-1:0]            stall_req;
  logic [NUM_STAGES-1:0]            redir_req;
  logic [NUM_STAGES*ADDR_WIDTH-1:0] redir_target;
  logic [NUM_STAGES:0]              stall;
  logic [NUM_STAGES:0]              flush;
  logic                             load_pc_we;
  logic [ADDR_WIDTH-1:0]            load_pc_new_pc;
  logic                             stats_clear;
  logic [SEL_W-1:0]                 stats_sel;
  logic [CNT_WIDTH-1:0]             stats_data;
  logic                             watchdog_trip;

  modport master (
    output stall_req, redir_req, redir_target, stats_clear, stats_sel,
    input  stall, flush, load_pc_we, load_pc_new_pc, stats_data, watchdog_trip
  );

  modport slave (
    input  stall_req, redir_req, redir_target, stats_clear, stats_sel,
    output stall, flush, load_pc_we, load_pc_new_pc, stats_data, watchdog_trip
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - parametrised stall/flush/redirect controller with stats and fetch watchdog
module pipeline_hazard_unit #(
  parameter int NUM_STAGES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DELAY_SLOTS    = 1,
  parameter int CNT_WIDTH      = 16,
  parameter int WATCHDOG_LIMIT = 1024
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  bus
);
  localparam int NCNT = 2 * NUM_STAGES + 1;
  localparam int WD_W = (WATCHDOG_LIMIT > 0) ? $clog2(WATCHDOG_LIMIT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_LIMIT);

  logic [NUM_STAGES-1:0] ds;
  logic [NUM_STAGES-1:0] kill;
  logic [NUM_STAGES-1:0] eff_req;
  logic [NUM_STAGES:0]   squash;
  logic [NUM_STAGES:0]   stall_w;
  logic [NUM_STAGES:0]   flush_w;
  logic                  redir_active;
  int                    redir_k;

  // Scanning upward lets the oldest unblocked requester overwrite younger ones.
  always_comb begin
    ds           = '0;
    redir_active = 1'b0;
    redir_k      = 0;
    kill         = '0;
    squash       = '0;
    stall_w      = '0;
    flush_w      = '0;
    for (int s = NUM_STAGES - 2; s >= 0; s--) begin
      ds[s] = ds[s+1] | bus.stall_req[s+1];
    end
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (bus.redir_req[s] && !ds[s]) begin
        redir_active = 1'b1;
        redir_k      = s;
      end
    end
    for (int t = 0; t < NUM_STAGES; t++) begin
      kill[t] = redir_active && (t <= redir_k - 1 - DELAY_SLOTS);
    end
    eff_req = bus.stall_req & ~kill;
    for (int r = NUM_STAGES - 1; r >= 0; r--) begin
      stall_w[r] = stall_w[r+1] | eff_req[r];
    end
    for (int r = 1; r <= NUM_STAGES; r++) begin
      squash[r] = redir_active && (r <= redir_k - DELAY_SLOTS);
    end
    for (int r = 0; r < NUM_STAGES; r++) begin
      flush_w[r+1] = (eff_req[r] | squash[r+1]) & ~stall_w[r+1];
    end
  end

  assign bus.stall          = stall_w;
  assign bus.flush          = flush_w;
  assign bus.load_pc_we     = redir_active;
  assign bus.load_pc_new_pc = redir_active ? bus.redir_target[redir_k*ADDR_WIDTH +: ADDR_WIDTH]
                                           : '0;

  logic [CNT_WIDTH-1:0] cnt_q [NCNT];
  logic [CNT_WIDTH-1:0] cnt_d [NCNT];
  logic [NCNT-1:0]      cnt_inc;

  always_comb begin
    cnt_inc = '0;
    for (int t = 0; t < NUM_STAGES; t++) begin
      cnt_inc[t]              = eff_req[t];
      cnt_inc[NUM_STAGES + t] = redir_active && (redir_k == t);
    end
    cnt_inc[NCNT-1] = 1'b1;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.stats_clear) begin
        cnt_d[i] = '0;
      end else if (cnt_inc[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCNT; i++) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    bus.stats_data = '0;
    if (int'(bus.stats_sel) < NCNT) begin
      bus.stats_data = cnt_q[bus.stats_sel];
    end
  end

  logic [WD_W-1:0] wd_q, wd_d;
  logic            trip_q, trip_d;

  // A PC overload means fetch is making progress even while the PC register reports stalled.
  always_comb begin
    wd_d   = wd_q;
    trip_d = trip_q;
    if (bus.stats_clear) begin
      wd_d   = '0;
      trip_d = 1'b0;
    end else if (WATCHDOG_LIMIT != 0) begin
      if (stall_w[0] && !redir_active) begin
        wd_d = (wd_q == WD_MAX) ? WD_MAX : wd_q + 1'b1;
      end else begin
        wd_d = '0;
      end
      if (wd_d == WD_MAX) begin
        trip_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q   <= '0;
      trip_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      trip_q <= trip_d;
    end
  end

  assign bus.watchdog_trip = trip_q;
endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised successor to the fixed five-stage hazard controller.
- Takes per-stage stall requests and per-stage redirect requests from NUM_STAGES requesting stages, and drives stall/flush to NUM_STAGES+1 pipeline registers.
- Drives load_pc with configurable branch-delay-slot depth.
- Adds sequential features: saturating hazard statistics counters (synthesisable replacement for the simulation-only event hooks) and a fetch-stall watchdog.

Parameters:
- NUM_STAGES, 4, number of request-capable stages (stage 0 = IF … NUM_STAGES-1 = MEM); stage NUM_STAGES = WB.
- ADDR_WIDTH, 32, PC width.
- DELAY_SLOTS, 1, number of architectural delay slots behind a redirecting instruction.
- CNT_WIDTH, 16, statistics counter width.
- WATCHDOG_LIMIT, 1024, consecutive fetch-stall cycles before trip; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stall_req  in  NUM_STAGES  stage t cannot advance this cycle (i-miss, lw hazard, d-miss, …)
- redir_req  in  NUM_STAGES  stage t requests PC redirect (jump / predicted-taken / mispredict)
- redir_target  in  NUM_STAGES*ADDR_WIDTH  target for stage t, slice [t*ADDR_WIDTH +: ADDR_WIDTH]
- stall  out  NUM_STAGES+1  stall[r]: hold register r (r=0 PC reg, register r feeds stage r)
- flush  out  NUM_STAGES+1  flush[r]: load bubble into register r
- load_pc_we  out  1  PC overload enable
- load_pc_new_pc  out  ADDR_WIDTH  overload PC
- stats_clear  in  1  synchronous clear of counters and watchdog
- stats_sel  in  $clog2(2*NUM_STAGES+1)  counter select
- stats_data  out  CNT_WIDTH  selected counter value
- watchdog_trip  out  1  sticky fetch-deadlock flag

Behaviour:
- Control outputs are combinational (0-cycle latency); only counters and watchdog are registered.
- Define ds(s) = OR stall_req[t] for t>s (downstream stall).
- Redirect:
  - The effective redirect stage k is the highest s with redir_req[s] & ~ds(s). The oldest instruction wins.
  - A redirect blocked by a downstream stall is ignored; the requester re-asserts it next cycle.
  - redirect_active = a k exists. load_pc_we = redirect_active; load_pc_new_pc = redir_target[k], else 0.
- Kill: when redirect_active, stall_req[t] is masked for t <= k-1-DELAY_SLOTS. eff_req[t] = stall_req[t] & ~kill[t].
- Stall: stall[r] = OR eff_req[t] for t>=r, for r in 0..NUM_STAGES-1; stall[NUM_STAGES] = 0.
- Flush:
  - flush[0] = 0.
  - flush[r+1] = (eff_req[r] | squash[r+1]) & ~stall[r+1].
  - squash[r] = redirect_active & 1 <= r <= k-DELAY_SLOTS.
  - Stall dominates flush on the same register.
- PC register: load_pc_we takes priority over stall[0].
- With NUM_STAGES=4 and DELAY_SLOTS=1, the block reproduces the existing controller:
  - Stage-1 redirect squashes nothing.
  - Stage-2 redirect squashes register 1 and overrides the IF miss.
- Counters (2*NUM_STAGES+1, saturating at all-ones, never wrap):
  - idx t (0..NUM_STAGES-1): cycles with eff_req[t].
  - idx NUM_STAGES+t: effective redirects from stage t.
  - idx 2*NUM_STAGES: total cycles.
- stats_data is the registered value (excludes the current cycle); an out-of-range stats_sel returns 0.
- Watchdog:
  - The counter increments each cycle stall[0] & ~load_pc_we, and clears to 0 otherwise.
  - When it reaches WATCHDOG_LIMIT, watchdog_trip sets and stays set until stats_clear or reset.
  - The counter saturates at WATCHDOG_LIMIT.
- stats_clear zeroes all counters, the watchdog counter and watchdog_trip. Clear beats a same-cycle increment.
- Reset (rst_n=0 at a posedge): all counters, the watchdog count and watchdog_trip go to 0. Reset mid-stall discards history.
- Combinational outputs follow their inputs during reset.

Test Plan:
- stall_req=4'b0001 → stall=5'b00001, flush=5'b00010, load_pc_we=0; counter 0 increments by 1 per cycle.
- stall_req=4'b0001, redir_req=4'b0100, redir_target[2]=0x0040_0100 → stall=0, flush=5'b00010, load_pc_we=1, new_pc=0x0040_0100; counter 6 = 1 after the edge.
- redir_req=4'b0110 (stage1 target 0x100, stage2 target 0x200) → new_pc=0x200; stage 2 wins; flush[1]=1.
- stall_req=4'b1000, redir_req=4'b0100 → load_pc_we=0, stall=5'b01111, flush=5'b10000.
- Counters: CNT_WIDTH=4, hold stall_req[1] for 20 cycles → counter 1 = 15 (saturated). Pulse stats_clear together with a stall → counter reads 0 next cycle.
- Watchdog: WATCHDOG_LIMIT=8, hold stall_req[0] for 7 cycles then release → no trip. Hold for 8 cycles → trip rises at the 8th edge and stays set after release until stats_clear.
